// File: rtl/l2s_lasso_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// l2s_lasso_monitor : liveness-to-safety lasso monitor for FG p properties
// Revision 1.0
// ---------------------------------------------------------------------------
module l2s_lasso_monitor #(
  parameter int WIDTH    = 8,
  parameter int NUM_FAIR = 1,
  parameter int LEN_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    state_in,
  input  logic                loop_start,
  input  logic                bad,
  input  logic [NUM_FAIR-1:0] fair,
  output logic [1:0]          fsm_state,
  output logic                loop_started,
  output logic                bad_seen,
  output logic [NUM_FAIR-1:0] fair_seen,
  output logic [LEN_W-1:0]    loop_len,
  output logic                loop_closed,
  output logic                violation,
  output logic                violation_q
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARMED  = 2'd1;
  localparam logic [1:0] ST_CLOSED = 2'd2;

  localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

  logic [1:0]          state_q,     state_d;
  logic [WIDTH-1:0]    shadow_q,    shadow_d;
  logic                bad_seen_q,  bad_seen_d;
  logic [NUM_FAIR-1:0] fair_seen_q, fair_seen_d;
  logic [LEN_W-1:0]    loop_len_q,  loop_len_d;
  logic                violation_d;

  // Closure is only meaningful while armed; the CLOSED state masks it.
  assign loop_closed = (state_q == ST_ARMED) && (state_in == shadow_q);
  assign violation   = loop_closed && bad_seen_q && (&fair_seen_q);

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    bad_seen_d  = bad_seen_q;
    fair_seen_d = fair_seen_q;
    loop_len_d  = loop_len_q;
    violation_d = violation_q;
    case (state_q)
      ST_IDLE: begin
        if (loop_start) begin
          shadow_d    = state_in;
          bad_seen_d  = bad;
          fair_seen_d = fair;
          loop_len_d  = '0;
          state_d     = ST_ARMED;
        end
      end
      ST_ARMED: begin
        bad_seen_d  = bad_seen_q | bad;
        fair_seen_d = fair_seen_q | fair;
        if (loop_len_q != LEN_MAX) begin
          loop_len_d = loop_len_q + {{(LEN_W-1){1'b0}}, 1'b1};
        end
        // A non-violating closure keeps accumulating: later revisits are lassos too.
        if (violation) begin
          state_d     = ST_CLOSED;
          violation_d = 1'b1;
        end
      end
      ST_CLOSED: begin
        state_d = ST_CLOSED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      shadow_q    <= '0;
      bad_seen_q  <= 1'b0;
      fair_seen_q <= '0;
      loop_len_q  <= '0;
      violation_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      bad_seen_q  <= bad_seen_d;
      fair_seen_q <= fair_seen_d;
      loop_len_q  <= loop_len_d;
      violation_q <= violation_d;
    end
  end

  assign fsm_state    = state_q;
  assign loop_started = (state_q == ST_ARMED) || (state_q == ST_CLOSED);
  assign bad_seen     = bad_seen_q;
  assign fair_seen    = fair_seen_q;
  assign loop_len     = loop_len_q;

endmodule
`default_nettype wire
